// File: rtl/actuator_matrix_scanner_if.sv
// Pad-side bundle of the actuator matrix scanner: SPI slave, scan control and matrix drive.
// Handshake: trigger_in_n / latch_data_n are falling-edge requests; trigger_out_n pulses low one cycle when a scan completes.
interface actuator_matrix_scanner_if #(
  parameter int ROWS = 5,
  parameter int COLS = 2
);
  logic                enable_n;
  logic                trigger_in_n;
  logic                latch_data_n;
  logic                sclk;
  logic                mosi;
  logic                ss_n;
  logic                miso;
  logic [ROWS-1:0]     rows;
  logic [COLS-1:0]     cols;
  logic [ROWS-1:0]     rows_enable;
  logic [COLS-1:0]     cols_enable;
  logic [2*ROWS-1:0]   rows_hbridge;
  logic [2*COLS-1:0]   cols_hbridge;
  logic                trigger_out_n;
  logic                busy;

  modport master (
    output enable_n, trigger_in_n, latch_data_n, sclk, mosi, ss_n,
    input  miso, rows, cols, rows_enable, cols_enable, rows_hbridge, cols_hbridge,
           trigger_out_n, busy
  );

  modport slave (
    input  enable_n, trigger_in_n, latch_data_n, sclk, mosi, ss_n,
    output miso, rows, cols, rows_enable, cols_enable, rows_hbridge, cols_hbridge,
           trigger_out_n, busy
  );
endinterface

// File: rtl/actuator_matrix_scanner.sv
// ROWS x COLS actuator matrix scanner: SPI-loaded double-buffered frame, per-cell dead-time
// plus H-bridge drive pulse, optional skipping of cells whose driven state is already correct.
module actuator_matrix_scanner #(
  parameter int ROWS         = 5,
  parameter int COLS         = 2,
  parameter int PULSE_CYCLES = 1000,
  parameter int DEAD_CYCLES  = 16,
  parameter int CNT_W        = 16,
  parameter int DIFF_ONLY    = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  actuator_matrix_scanner_if.slave bus,
  output logic [2:0]               state_dbg
);

  localparam int CELLS = ROWS * COLS;
  localparam int K_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int C_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [K_W-1:0]   K_LAST     = K_W'(CELLS - 1);
  localparam logic [C_W-1:0]   C_LAST     = C_W'(COLS - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [7:0]       FRAME_BITS = 8'(CELLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_DEAD  = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // All pad inputs are raw; flops reset to 1, the idle level of the active-low pins.
  logic [5:0] pad_raw, sync_a, sync_b;
  logic [3:0] edge_prev;
  assign pad_raw = {bus.enable_n, bus.trigger_in_n, bus.latch_data_n, bus.sclk, bus.mosi, bus.ss_n};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a    <= '1;
      sync_b    <= '1;
      edge_prev <= '1;
    end else begin
      sync_a    <= pad_raw;
      sync_b    <= sync_a;
      edge_prev <= {sync_b[4], sync_b[3], sync_b[2], sync_b[0]};
    end
  end

  logic en_off, trig_fall, latch_fall, sclk_rise, mosi_s, ss_s, ss_fall, ss_rise;
  assign en_off     = sync_b[5];
  assign trig_fall  = edge_prev[3] & ~sync_b[4];
  assign latch_fall = edge_prev[2] & ~sync_b[3];
  assign sclk_rise  = ~edge_prev[1] & sync_b[2];
  assign mosi_s     = sync_b[1];
  assign ss_s       = sync_b[0];
  assign ss_fall    = edge_prev[0] & ~sync_b[0];
  assign ss_rise    = ~edge_prev[0] & sync_b[0];

  logic [CELLS-1:0] shift_reg, shadow, active, applied;
  logic [7:0]       bit_cnt;
  logic             miso_q;

  // A frame of the wrong length leaves the shadow untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      shadow    <= '0;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
    end else begin
      if (ss_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && !ss_s) begin
        shift_reg <= {shift_reg[CELLS-2:0], mosi_s};
        bit_cnt   <= bit_cnt + 8'd1;
      end
      if (ss_rise && (bit_cnt == FRAME_BITS)) shadow <= shift_reg;
      miso_q <= ~ss_s & shift_reg[CELLS-1];
    end
  end

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d, k_inc;
  logic [R_W-1:0]   r_q, r_d, r_inc;
  logic [C_W-1:0]   c_q, c_d, c_inc;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             applied_valid, latch_pend;
  logic             applied_wr, scan_done, last_cell, skip_cell;

  assign k_inc     = k_q + 1'b1;
  assign c_inc     = (c_q == C_LAST) ? '0 : c_q + 1'b1;
  assign r_inc     = (c_q == C_LAST) ? r_q + 1'b1 : r_q;
  assign last_cell = (k_q == K_LAST);
  assign skip_cell = (DIFF_ONLY != 0) && applied_valid && (active[k_q] == applied[k_q]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    r_d        = r_q;
    c_d        = c_q;
    timer_d    = timer_q;
    applied_wr = 1'b0;
    scan_done  = 1'b0;
    if (en_off) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig_fall) begin
            state_d = S_EVAL;
            k_d     = '0;
            r_d     = '0;
            c_d     = '0;
          end
        end
        S_EVAL: begin
          if (skip_cell) begin
            if (last_cell) begin
              state_d = S_DONE;
            end else begin
              k_d = k_inc;
              r_d = r_inc;
              c_d = c_inc;
            end
          end else begin
            state_d = S_DEAD;
            timer_d = '0;
          end
        end
        S_DEAD: begin
          if (timer_q == DEAD_LAST) begin
            state_d = S_PULSE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_PULSE: begin
          if (timer_q == PULSE_LAST) begin
            applied_wr = 1'b1;
            if (last_cell) begin
              state_d = S_DONE;
            end else begin
              state_d = S_EVAL;
              k_d     = k_inc;
              r_d     = r_inc;
              c_d     = c_inc;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d   = S_IDLE;
          scan_done = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The active frame only moves while idle, or at the end of a scan if a latch arrived during it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active        <= '0;
      applied       <= '0;
      applied_valid <= 1'b0;
      latch_pend    <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        if (latch_fall) begin
          active     <= shadow;
          latch_pend <= 1'b0;
        end
      end else if (scan_done) begin
        if (latch_pend || latch_fall) active <= shadow;
        latch_pend <= 1'b0;
      end else if (latch_fall) begin
        latch_pend <= 1'b1;
      end
      if (applied_wr) applied[k_q] <= active[k_q];
      if (en_off) applied_valid <= 1'b0;
      else if (scan_done) applied_valid <= 1'b1;
    end
  end

  // Drive is decoded from the next state so every pad output comes straight from a flop.
  logic [ROWS-1:0]   rows_d, rows_q, rows_en_q;
  logic [COLS-1:0]   cols_d, cols_q;
  logic [2*ROWS-1:0] rows_hb_d, rows_hb_q;
  logic [2*COLS-1:0] cols_hb_d, cols_hb_q;
  logic              trig_out_q, busy_q;

  always_comb begin
    rows_d    = '0;
    cols_d    = '0;
    rows_hb_d = '0;
    cols_hb_d = '0;
    if (state_d == S_PULSE) begin
      rows_d[r_d] = 1'b1;
      cols_d[c_d] = 1'b1;
      if (active[k_d]) begin
        rows_hb_d[{r_d, 1'b1}] = 1'b1;
        cols_hb_d[{c_d, 1'b0}] = 1'b1;
      end else begin
        rows_hb_d[{r_d, 1'b0}] = 1'b1;
        cols_hb_d[{c_d, 1'b1}] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rows_q     <= '0;
      cols_q     <= '0;
      rows_hb_q  <= '0;
      cols_hb_q  <= '0;
      rows_en_q  <= '0;
      trig_out_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      rows_hb_q  <= rows_hb_d;
      cols_hb_q  <= cols_hb_d;
      rows_en_q  <= {ROWS{~en_off}};
      trig_out_q <= (state_d != S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.miso          = miso_q;
  assign bus.rows          = rows_q;
  assign bus.cols          = cols_q;
  assign bus.rows_hbridge  = rows_hb_q;
  assign bus.cols_hbridge  = cols_hb_q;
  assign bus.rows_enable   = rows_en_q;
  assign bus.cols_enable   = {COLS{rows_en_q[0]}};
  assign bus.trigger_out_n = trig_out_q;
  assign bus.busy          = busy_q;
  assign state_dbg         = state_q;

endmodule
